// File: rtl/wb_pkg.sv
// Shared Wishbone bus definitions: default widths, arbiter state type and a
// generic round-robin search reused by bus arbiters.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 25;
  localparam int WB_DATA_WIDTH = 64;
  localparam int RR_MAX_N      = 8;
  localparam int RR_IDX_W      = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after last+1, wrapping modulo n (n need not be a power of two).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] last,
                                       input int                  n);
    rr_pick_t            res;
    logic [RR_IDX_W:0]   sum;
    res = '0;
    for (int i = 1; i <= RR_MAX_N; i++) begin
      if (i <= n) begin
        sum = {1'b0, last} + (RR_IDX_W+1)'(i);
        if (sum >= (RR_IDX_W+1)'(n)) sum = sum - (RR_IDX_W+1)'(n);
        if (!res.vld && req[sum[RR_IDX_W-1:0]]) begin
          res.vld = 1'b1;
          res.idx = sum[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search over N requesters, starting after 'last'.
module rr_priority_picker
  import wb_pkg::*;
#(
  parameter int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          valid
);

  rr_pick_t res;

  assign res   = rr_pick(RR_MAX_N'(req), RR_IDX_W'(last), N);
  assign pick  = IW'(res.idx);
  assign valid = res.vld;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic-cycle arbiter: N masters share one slave port,
// grant held for the whole cyc and handed over back-to-back on release.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTERS  = 3,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  localparam int SEL_WIDTH = DATA_WIDTH / 8,
  localparam int IW        = $clog2(N_MASTERS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [N_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [N_MASTERS-1:0]            m_we_i,
  input  logic [N_MASTERS-1:0]            m_cyc_i,
  input  logic [N_MASTERS-1:0]            m_stb_i,
  output logic [N_MASTERS-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]           m_dat_o,
  output logic [ADDR_WIDTH-1:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic [SEL_WIDTH-1:0]            s_sel_o,
  output logic                            s_we_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  input  logic                            s_ack_i,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  output logic [N_MASTERS-1:0]            grant_o
);

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        pick;
  logic                 pick_vld;

  // The current holder is masked out so a release re-arbitrates among the others.
  rr_priority_picker #(.N(N_MASTERS)) u_picker (
    .req   (m_cyc_i & ~grant_q),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = N_MASTERS'(1) << pick;
          last_d  = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // last_q always names the holder while BUSY.
        if (!m_cyc_i[last_q]) begin
          if (pick_vld) begin
            grant_d = N_MASTERS'(1) << pick;
            last_d  = pick;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign s_we_o  = |(grant_q & m_we_i);
  assign s_cyc_o = |(grant_q & m_cyc_i);
  assign s_stb_o = |(grant_q & m_stb_i);

  // A late slave ack after a handover only reaches a grantee that is strobing.
  assign m_ack_o = grant_q & m_stb_i & {N_MASTERS{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

endmodule
